// File: rtl/sipo_deframer.sv
// -----------------------------------------------------------------------------
// sipo_deframer
//   Parametrised serial-in / parallel-out deserializer. Collects LANES bits per
//   accepted beat into a DATA_WIDTH-bit word and presents completed words on a
//   registered valid/ready output port. Bit order is chosen per word by
//   msb_first, sampled on the first beat of the word. A partial word can be
//   discarded with flush.
//
// Parameters
//   DATA_WIDTH  assembled word width (multiple of LANES)
//   LANES       bits accepted per beat; DATA_WIDTH/LANES must be >= 2
//
// Ports
//   clk         clock, rising edge
//   resetn      synchronous active-low reset
//   din_valid   input beat valid
//   din         input beat data (LANES bits)
//   din_ready   beat can be accepted this cycle (combinational)
//   msb_first   1 = first beat lands in the MSBs (sampled on first beat)
//   flush       discard the partial word and any beat presented this cycle
//   dout        assembled word
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer takes dout this cycle
//   fill_level  beats of the partial word already accepted
// -----------------------------------------------------------------------------
module sipo_deframer #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 1,
   localparam int BEATS     = DATA_WIDTH / LANES,
   localparam int CW        = (BEATS > 2) ? $clog2(BEATS) : 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  din_valid,
   input  logic [LANES-1:0]      din,
   output logic                  din_ready,
   input  logic                  msb_first,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [CW-1:0]         fill_level
);

   logic [DATA_WIDTH-1:0] sreg;
   logic [DATA_WIDTH-1:0] sreg_next;
   logic [CW-1:0]         cnt;
   logic                  order_q;
   logic                  eff_order;
   logic                  last_beat;
   logic                  acc;
   logic                  word_done;

   always_comb begin
      last_beat = (cnt == CW'(BEATS - 1));
      // Only the final beat can stall: it would overwrite an unconsumed word.
      din_ready = !(last_beat && dout_valid && !dout_ready);
      acc       = din_valid && din_ready;
      // The first beat of a word uses the live msb_first; later beats use the
      // order latched with that first beat.
      eff_order = (cnt == '0) ? msb_first : order_q;
      word_done = acc && last_beat && !flush;
      if (eff_order) begin
         sreg_next = (sreg << LANES) | DATA_WIDTH'(din);
      end else begin
         sreg_next = (sreg >> LANES) | {din, {(DATA_WIDTH-LANES){1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sreg       <= '0;
         cnt        <= '0;
         order_q    <= 1'b1;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         if (flush) begin
            // A beat presented alongside flush is dropped; order latch untouched.
            sreg <= '0;
            cnt  <= '0;
         end else if (acc) begin
            if (cnt == '0) begin
               order_q <= msb_first;
            end
            if (last_beat) begin
               dout <= sreg_next;
               sreg <= '0;
               cnt  <= '0;
            end else begin
               sreg <= sreg_next;
               cnt  <= cnt + CW'(1);
            end
         end

         // A completing word takes priority over consumption, so a word that
         // finishes in the same cycle the old one is taken keeps valid high.
         if (word_done) begin
            dout_valid <= 1'b1;
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

   assign fill_level = cnt;

endmodule

// File: tb/tb_sipo_deframer.sv
module tb_sipo_deframer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance 0: DATA_WIDTH=16, LANES=1
   logic        resetn1, din_valid1, din1, din_ready1, msb_first1, flush1;
   logic        dout_valid1, dout_ready1;
   logic [15:0] dout1;
   logic [3:0]  fill1;

   // instance 1: DATA_WIDTH=16, LANES=4
   logic        resetn4, din_valid4, din_ready4, msb_first4, flush4;
   logic        dout_valid4, dout_ready4;
   logic [3:0]  din4;
   logic [15:0] dout4;
   logic [1:0]  fill4;

   sipo_deframer #(.DATA_WIDTH(16), .LANES(1)) u_dut1 (
      .clk(clk), .resetn(resetn1), .din_valid(din_valid1), .din(din1),
      .din_ready(din_ready1), .msb_first(msb_first1), .flush(flush1),
      .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready1),
      .fill_level(fill1)
   );

   sipo_deframer #(.DATA_WIDTH(16), .LANES(4)) u_dut4 (
      .clk(clk), .resetn(resetn4), .din_valid(din_valid4), .din(din4),
      .din_ready(din_ready4), .msb_first(msb_first4), .flush(flush4),
      .dout(dout4), .dout_valid(dout_valid4), .dout_ready(dout_ready4),
      .fill_level(fill4)
   );

   int errors = 0;
   int checks = 0;
   int cur    = 0;   // instance under test: 0 -> LANES=1, 1 -> LANES=4

   // Reference model: beats collected in an array, word built arithmetically
   // from the bit-order rule once a full word's worth of beats is present.
   int          m_lanes [2] = '{1, 4};
   bit          m_known [2];
   int          m_cnt   [2];
   logic [3:0]  m_bt    [2][16];
   bit          m_order [2];
   bit          m_valid [2];
   logic [15:0] m_word  [2];

   function automatic bit exp_ready(int i, bit rdy);
      return !((m_cnt[i] == 16 / m_lanes[i] - 1) && m_valid[i] && !rdy);
   endfunction

   function automatic logic [15:0] build(int i, bit order);
      logic [15:0] w;
      int L;
      int nb;
      w  = '0;
      L  = m_lanes[i];
      nb = 16 / L;
      for (int k = 0; k < nb; k++) begin
         logic [15:0] beat;
         beat = 16'(m_bt[i][k]) & 16'((1 << L) - 1);
         if (order) w = w | (beat << (16 - L * (k + 1)));
         else       w = w | (beat << (L * k));
      end
      return w;
   endfunction

   // One clock of stimulus for the current instance, followed by model update.
   task automatic step(bit rst, bit v, logic [3:0] d, bit mf, bit fl, bit rdy);
      bit acc;
      if (cur == 0) begin
         resetn1 = !rst; din_valid1 = v; din1 = d[0]; msb_first1 = mf;
         flush1 = fl; dout_ready1 = rdy;
      end else begin
         resetn4 = !rst; din_valid4 = v; din4 = d; msb_first4 = mf;
         flush4 = fl; dout_ready4 = rdy;
      end
      acc = v && exp_ready(cur, rdy);
      @(posedge clk);
      #1;
      if (rst) begin
         m_cnt[cur]   = 0;
         m_order[cur] = 1'b1;
         m_valid[cur] = 1'b0;
         m_word[cur]  = '0;
         m_known[cur] = 1'b1;
      end else if (m_known[cur]) begin
         if (m_valid[cur] && rdy) m_valid[cur] = 1'b0;
         if (fl) begin
            m_cnt[cur] = 0;
         end else if (acc) begin
            if (m_cnt[cur] == 0) m_order[cur] = mf;
            m_bt[cur][m_cnt[cur]] = d;
            m_cnt[cur]++;
            if (m_cnt[cur] == 16 / m_lanes[cur]) begin
               m_word[cur]  = build(cur, m_order[cur]);
               m_valid[cur] = 1'b1;
               m_cnt[cur]   = 0;
            end
         end
      end
   endtask

   // Scoreboard: compare the instance under test with the model every cycle.
   always @(negedge clk) begin : monitor
      logic        rd, dv, r;
      logic [15:0] dw;
      int          fl;
      if (m_known[cur]) begin
         if (cur == 0) begin
            rd = din_ready1; dv = dout_valid1; dw = dout1; fl = int'(fill1); r = dout_ready1;
         end else begin
            rd = din_ready4; dv = dout_valid4; dw = dout4; fl = int'(fill4); r = dout_ready4;
         end
         checks += 4;
         if (rd !== exp_ready(cur, r)) begin
            errors++;
            $display("FAIL model_din_ready inst%0d t=%0t: got %b expected %b", cur, $time, rd, exp_ready(cur, r));
         end
         if (dv !== m_valid[cur]) begin
            errors++;
            $display("FAIL model_dout_valid inst%0d t=%0t: got %b expected %b", cur, $time, dv, m_valid[cur]);
         end
         if (dw !== m_word[cur]) begin
            errors++;
            $display("FAIL model_dout inst%0d t=%0t: got %h expected %h", cur, $time, dw, m_word[cur]);
         end
         if (fl != m_cnt[cur]) begin
            errors++;
            $display("FAIL model_fill_level inst%0d t=%0t: got %0d expected %0d", cur, $time, fl, m_cnt[cur]);
         end
      end
   end

   task automatic begin_inst(int i);
      cur = i;
      m_known[i] = 1'b0;
      step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      begin_inst(1);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      checks += 3;
      if (dout4 !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", dout4); end
      if (dout_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid4); end
      if (fill4 !== 2'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill4); end
   endtask

   task automatic test_lane1_msb();
      logic [15:0] w;
      w = 16'hA5C3;
      begin_inst(0);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (int'(fill1) != k) begin errors++; $display("FAIL l1_fill_step%0d: got %0d expected %0d", k, fill1, k); end
         step(1'b0, 1'b1, {3'b0, w[15-k]}, 1'b1, 1'b0, 1'b1);
      end
      checks += 3;
      if (dout1 !== 16'hA5C3) begin errors++; $display("FAIL l1_msb_word: got %h expected a5c3", dout1); end
      if (dout_valid1 !== 1'b1) begin errors++; $display("FAIL l1_msb_valid: got %b expected 1", dout_valid1); end
      if (fill1 !== 4'd0) begin errors++; $display("FAIL l1_msb_fill: got %0d expected 0", fill1); end
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (dout_valid1 !== 1'b0) begin errors++; $display("FAIL l1_msb_pulse: got %b expected 0", dout_valid1); end
   endtask

   task automatic test_lane1_lsb();
      logic [15:0] w, w2;
      w  = 16'hA5C3;
      w2 = 16'($urandom);
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, {3'b0, w[k]}, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dout1 !== 16'hA5C3) begin errors++; $display("FAIL l1_lsb_word: got %h expected a5c3", dout1); end
      // order changes after beat 3 must not affect this word
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, {3'b0, w2[k]}, (k >= 3), 1'b0, 1'b1);
      checks++;
      if (dout1 !== w2) begin errors++; $display("FAIL l1_order_latch: got %h expected %h", dout1, w2); end
   endtask

   task automatic test_lane4_order();
      begin_inst(1);
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 4'(k), 1'b1, 1'b0, 1'b1);
      checks++;
      if (dout4 !== 16'h1234) begin errors++; $display("FAIL l4_msb_word: got %h expected 1234", dout4); end
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 4'(k), 1'b0, 1'b0, 1'b1);
      checks += 2;
      if (dout4 !== 16'h4321) begin errors++; $display("FAIL l4_lsb_word: got %h expected 4321", dout4); end
      if (dout_valid4 !== 1'b1) begin errors++; $display("FAIL l4_back_to_back_valid: got %b expected 1", dout_valid4); end
   endtask

   task automatic test_backpressure();
      begin_inst(1);
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 4'(k), 1'b1, 1'b0, 1'b0);
      for (int k = 5; k <= 7; k++) step(1'b0, 1'b1, 4'(k), 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
         checks += 3;
         if (dout4 !== 16'h1234) begin errors++; $display("FAIL bp_hold_dout c%0d: got %h expected 1234", c, dout4); end
         if (dout_valid4 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %b expected 1", c, dout_valid4); end
         if (fill4 !== 2'd3) begin errors++; $display("FAIL bp_hold_fill c%0d: got %0d expected 3", c, fill4); end
      end
      step(1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b1);
      checks += 3;
      if (dout4 !== 16'h5678) begin errors++; $display("FAIL bp_swap_dout: got %h expected 5678", dout4); end
      if (dout_valid4 !== 1'b1) begin errors++; $display("FAIL bp_swap_valid: got %b expected 1", dout_valid4); end
      if (fill4 !== 2'd0) begin errors++; $display("FAIL bp_swap_fill: got %0d expected 0", fill4); end
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (dout_valid4 !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b expected 0", dout_valid4); end
   endtask

   task automatic test_flush();
      begin_inst(1);
      step(1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b1);
      checks++;
      if (fill4 !== 2'd0) begin errors++; $display("FAIL flush_fill: got %0d expected 0", fill4); end
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 4'(k), 1'b1, 1'b0, 1'b1);
      checks++;
      if (dout4 !== 16'h1234) begin errors++; $display("FAIL flush_next_word: got %h expected 1234", dout4); end
   endtask

   task automatic test_reset_midword();
      begin_inst(1);
      step(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
      checks += 2;
      if (fill4 !== 2'd2) begin errors++; $display("FAIL rst_mid_fill_pre: got %0d expected 2", fill4); end
      if (dout_valid4 !== 1'b1) begin errors++; $display("FAIL rst_mid_valid_pre: got %b expected 1", dout_valid4); end
      step(1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
      checks += 3;
      if (dout4 !== 16'h0000) begin errors++; $display("FAIL rst_mid_dout: got %h expected 0000", dout4); end
      if (dout_valid4 !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", dout_valid4); end
      if (fill4 !== 2'd0) begin errors++; $display("FAIL rst_mid_fill: got %0d expected 0", fill4); end
      step(1'b0, 1'b1, 4'hD, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (dout4 !== 16'hDEF0) begin errors++; $display("FAIL rst_mid_fresh_word: got %h expected def0", dout4); end
   endtask

   task automatic test_random(int i, int n);
      begin_inst(i);
      for (int c = 0; c < n; c++) begin
         step(1'b0,
              ($urandom_range(0, 3) != 0),
              4'($urandom),
              1'($urandom),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 2) != 0));
      end
   endtask

   initial begin
      resetn1 = 1'b0; din_valid1 = 1'b0; din1 = 1'b0; msb_first1 = 1'b1; flush1 = 1'b0; dout_ready1 = 1'b1;
      resetn4 = 1'b0; din_valid4 = 1'b0; din4 = 4'h0; msb_first4 = 1'b1; flush4 = 1'b0; dout_ready4 = 1'b1;
      test_reset();
      test_lane1_msb();
      test_lane1_lsb();
      test_lane4_order();
      test_backpressure();
      test_flush();
      test_reset_midword();
      test_random(1, 600);
      test_random(0, 600);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Parametrised serial-in/parallel-out deserializer. Successor to the single-bit always-shifting SIPO register.
- Accepts LANES bits per beat under a valid/ready handshake and assembles DATA_WIDTH-bit words. Bit order is selectable per word.
- Completed words are presented on a registered valid/ready output port with backpressure. A partial word can be abandoned with flush.
- Sits between serial/narrow-lane receivers and word-wide datapath logic.

Parameters:
- DATA_WIDTH, 16, assembled word width in bits. Must be a multiple of LANES.
- LANES, 1, bits accepted per input beat (1, 2, 4, 8 typical). BEATS = DATA_WIDTH/LANES must be >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  synchronous, active-low reset
- din_valid  in  1  input beat valid
- din  in  LANES  input beat data
- din_ready  out  1  block can accept a beat this cycle
- msb_first  in  1  bit order, 1 = first beat lands in the MSBs; sampled on the first beat of each word
- flush  in  1  discard the partial word
- dout  out  DATA_WIDTH  assembled word
- dout_valid  out  1  dout holds an unconsumed word
- dout_ready  in  1  consumer accepts dout this cycle
- fill_level  out  CW = max(1, $clog2(BEATS))  beats of the current partial word already accepted (0..BEATS-1)

Behaviour:
- Reset (resetn=0 at a clk edge): shift register=0, beat count=0, latched order=1, dout=0, dout_valid=0. All other inputs are ignored that cycle, and an in-progress word is lost.
- Accept: acc = din_valid & din_ready. din_ready is combinational: din_ready = !(cnt==BEATS-1 && dout_valid && !dout_ready). Only the final beat of a word can stall.
- Order latch: on an accepted beat with cnt==0, the effective order = msb_first and it is latched. Beats with cnt>0 use the latched order, so msb_first changes mid-word have no effect.
- MSB-first: sreg_next = (sreg << LANES) | din. The first beat ends in bits [DATA_WIDTH-1 : DATA_WIDTH-LANES].
- LSB-first: sreg_next = (sreg >> LANES) | (din << (DATA_WIDTH-LANES)). The first beat ends in bits [LANES-1:0].
- Non-final accepted beat: sreg <= sreg_next, cnt <= cnt+1.
- Final accepted beat (cnt==BEATS-1):
  - dout <= sreg_next, dout_valid <= 1.
  - sreg <= 0, cnt <= 0.
  - Latency: the word is visible on dout the cycle after the last beat is accepted.
- Output handshake:
  - If dout_valid & dout_ready and no new word completes, dout_valid <= 0 and dout holds its last value.
  - If a word completes in the same cycle the old word is consumed, dout is replaced and dout_valid stays 1. No bubble, no loss.
  - dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
- Flush:
  - When flush=1, sreg <= 0 and cnt <= 0. Any beat presented that cycle is dropped even if din_ready=1, and the latched order is not updated.
  - Flush does not affect dout/dout_valid; an output handshake in the same cycle completes normally.
- fill_level = cnt. It returns to 0 after the final beat and after flush.
- No overrun is possible: completing a word while output is blocked is prevented by din_ready.

Test Plan:
- DATA_WIDTH=16, LANES=1, msb_first=1, dout_ready=1. Send bits of 0xA5C3 MSB first on 16 consecutive cycles -> dout=0xA5C3 with a 1-cycle dout_valid pulse, the cycle after beat 16. fill_level steps 0..15 then returns to 0.
- Same config, msb_first=0. Send 0xA5C3 LSB first -> dout=0xA5C3. Then toggle msb_first to 1 after beat 3 of the next word -> that word still assembles LSB-first.
- LANES=4, DATA_WIDTH=16. Beats 0x1,0x2,0x3,0x4 with msb_first=1 -> dout=0x1234. Same beats with msb_first=0 -> dout=0x4321.
- LANES=4, dout_ready=0.
  - First word 0x1234 is held.
  - Second word beats 0x5,0x6,0x7 are accepted; on beat 0x8, din_ready=0 and the beat is held for 5 cycles.
  - Raise dout_ready -> 0x1234 consumed and 0x5678 captured in the same cycle; dout_valid stays 1.
- LANES=4: send 0xA,0xB, then assert flush together with beat 0xC -> fill_level=0 and 0xC dropped. Next 4 beats 0x1,0x2,0x3,0x4 -> dout=0x1234.
- Reset mid-word (fill_level=2) with dout_valid=1 -> next cycle dout=0, dout_valid=0, fill_level=0. A fresh 4-beat word assembles correctly.
